// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and its receive FIFO.
package uart_pkg;

  // Data word width shared by the receiver and the FIFO behind it.
  localparam int unsigned UART_DBIT = 8;

  // How the occupancy counter moves in a given cycle.
  typedef enum logic [1:0] {
    CntHold,
    CntInc,
    CntDec
  } cnt_op_e;

  // Simultaneous accepted write and effective read cancel out.
  function automatic cnt_op_e cnt_op(input logic wr_en, input logic rd_en);
    if (wr_en && !rd_en) begin
      return CntInc;
    end else if (rd_en && !wr_en) begin
      return CntDec;
    end else begin
      return CntHold;
    end
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the UART receive FIFO: one synchronous write
// port, one asynchronous read port, no reset.
module uart_fifo_mem #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DBIT-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DBIT-1:0]   rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DBIT-1:0] mem [Depth];

  // Write port; contents are never reset since they are masked while empty.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with a
// sticky overrun flag for words dropped while full.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT   = UART_DBIT,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_tick,
  input  logic [DBIT-1:0] din,
  input  logic            rd,
  output logic [DBIT-1:0] dout,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overrun,
  input  logic            clr_overrun
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              wr_en, rd_en;
  logic [DBIT-1:0]   mem_rdata;

  // count never exceeds 2**ADDR_W, so its MSB alone marks the full state.
  assign empty   = (count_q == '0);
  assign full    = count_q[ADDR_W];
  assign count   = count_q;
  assign overrun = overrun_q;

  // Head word is masked to zero while empty so stale memory never shows.
  assign dout = empty ? '0 : mem_rdata;

  // Accept/pop decisions and next-state for pointers, count and overrun.
  always_comb begin
    rd_en     = rd & ~empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    wr_en     = wr_tick & (~full | rd);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    unique case (cnt_op(wr_en, rd_en))
      CntInc:  count_d = count_q + (ADDR_W + 1)'(1);
      CntDec:  count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // Setting takes priority over a coincident clear.
    if (wr_tick && full && !rd) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  uart_fifo_mem #(
    .DBIT  (DBIT),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

endmodule
